// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: register-number width, bypass-select encoding and
// the shadow-pipe stage record.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] wa;
    logic              ld;
  } stage_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Bypass select for one EX operand: compares the ID source against the EX and MEM
// shadow records and picks the youngest valid producer.
module hazard_fwd_sel
  import cpu_pkg::*;
(
  input  logic              use_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              ex_vld_i,
  input  logic [REG_AW-1:0] ex_wa_i,
  input  logic              ex_ld_i,
  input  logic              mem_vld_i,
  input  logic [REG_AW-1:0] mem_wa_i,
  output logic [FWD_W-1:0]  sel_c
);

  logic src_live;

  assign src_live = use_i && (src_i != '0);

  // A load still in EX has no data yet; the load-use stall turns it into a WB bypass.
  always_comb begin
    sel_c = FWD_RF;
    if (src_live && ex_vld_i && (ex_wa_i == src_i) && !ex_ld_i) begin
      sel_c = FWD_MEM;
    end else if (src_live && mem_vld_i && (mem_wa_i == src_i)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: shadow destination pipe, load-use stall,
// branch flush, registered EX bypass selects and a saturating stall counter.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_wa,
  input  logic              id_is_load,
  input  logic              id_br_taken,
  input  logic              mem_stall,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic [FWD_W-1:0]  fwd_a_sel,
  output logic [FWD_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The WB record is not kept: no select or hazard ever depends on it.
  stage_t            ex_q, ex_d;
  logic              mem_vld_q;
  logic [REG_AW-1:0] mem_wa_q;
  logic [FWD_W-1:0]  fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              lu_c;
  logic [FWD_W-1:0]  fwd_a_c, fwd_b_c;

  assign lu_c = ex_q.vld && ex_q.ld &&
                ((id_use_rs && (id_rs == ex_q.wa)) || (id_use_rt && (id_rt == ex_q.wa)));

  // Output priority: memory wait, then load-use, then branch flush.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    if (mem_stall) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else if (lu_c) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else begin
      flush_ifid = id_br_taken;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!bubble_idex) begin
      ex_d.vld = id_wreg && (id_wa != '0);
      ex_d.wa  = id_wa;
      ex_d.ld  = id_is_load;
    end
  end

  hazard_fwd_sel u_fwd_a (
    .use_i     (id_use_rs),
    .src_i     (id_rs),
    .ex_vld_i  (ex_q.vld),
    .ex_wa_i   (ex_q.wa),
    .ex_ld_i   (ex_q.ld),
    .mem_vld_i (mem_vld_q),
    .mem_wa_i  (mem_wa_q),
    .sel_c     (fwd_a_c)
  );

  hazard_fwd_sel u_fwd_b (
    .use_i     (id_use_rt),
    .src_i     (id_rt),
    .ex_vld_i  (ex_q.vld),
    .ex_wa_i   (ex_q.wa),
    .ex_ld_i   (ex_q.ld),
    .mem_vld_i (mem_vld_q),
    .mem_wa_i  (mem_wa_q),
    .sel_c     (fwd_b_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_vld_q   <= 1'b0;
      mem_wa_q    <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else if (!mem_stall) begin
      ex_q      <= ex_d;
      mem_vld_q <= ex_q.vld;
      mem_wa_q  <= ex_q.wa;
      fwd_a_q   <= bubble_idex ? FWD_RF : fwd_a_c;
      fwd_b_q   <= bubble_idex ? FWD_RF : fwd_b_c;
      if (lu_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a narrow counter makes saturation reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs, id_rt, id_wa;
  logic          id_use_rs, id_use_rt, id_wreg, id_is_load, id_br_taken, mem_stall;
  logic          stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_wa(id_wa), .id_is_load(id_is_load),
    .id_br_taken(id_br_taken), .mem_stall(mem_stall),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic wreg, input logic [4:0] wa,
                        input logic ld);
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wreg = wreg; id_wa = wa; id_is_load = ld; id_br_taken = 1'b0;
    #1;
  endtask

  task automatic idle();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_stall = 1'b0;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_stall = 1'b0;
    idle();
    id_br_taken = 1'b1;
    #1;
    n_checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      $display("FAIL reset_sels got=%b/%b exp=00/00", fwd_a_sel, fwd_b_sel); n_fail++;
    end
    n_checks++;
    if (stall_cnt !== 3'd0) begin
      $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); n_fail++;
    end
    n_checks++;
    if ({stall_pc, stall_ifid, bubble_idex, flush_ifid} !== 4'b0001) begin
      $display("FAIL reset_comb got=%b exp=0001",
               {stall_pc, stall_ifid, bubble_idex, flush_ifid}); n_fail++;
    end
    id_br_taken = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);   // add r3
    tick();
    set_id(5'd3, 1'b1, 5'd6, 1'b1, 1'b1, 5'd7, 1'b0);   // reads r3
    n_checks++;
    if (stall_pc !== 1'b0 || bubble_idex !== 1'b0) begin
      $display("FAIL chain_nostall got=%b%b exp=00", stall_pc, bubble_idex); n_fail++;
    end
    tick();
    n_checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      $display("FAIL chain_ex got=%b/%b exp=01/00", fwd_a_sel, fwd_b_sel); n_fail++;
    end
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);   // third reads r3
    tick();
    n_checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      $display("FAIL chain_mem got=%b/%b exp=10/00", fwd_a_sel, fwd_b_sel); n_fail++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw r5
    tick();
    set_id(5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0);   // reads r5 as rt
    n_checks++;
    if ({stall_pc, stall_ifid, bubble_idex, flush_ifid} !== 4'b1110) begin
      $display("FAIL lu_comb got=%b exp=1110",
               {stall_pc, stall_ifid, bubble_idex, flush_ifid}); n_fail++;
    end
    tick();
    n_checks++;
    if (stall_cnt !== 3'd1 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      $display("FAIL lu_bubble got=cnt%0d %b/%b exp=cnt1 00/00", stall_cnt, fwd_a_sel, fwd_b_sel);
      n_fail++;
    end
    n_checks++;
    if (stall_pc !== 1'b0 || bubble_idex !== 1'b0) begin
      $display("FAIL lu_release got=%b%b exp=00", stall_pc, bubble_idex); n_fail++;
    end
    tick();
    n_checks++;
    if (fwd_b_sel !== 2'b10 || fwd_a_sel !== 2'b00 || stall_cnt !== 3'd1) begin
      $display("FAIL lu_fwd got=%b/%b cnt%0d exp=00/10 cnt1", fwd_a_sel, fwd_b_sel, stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);   // lw r0
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);   // add r0 <- r0,r0
    n_checks++;
    if (stall_pc !== 1'b0 || bubble_idex !== 1'b0) begin
      $display("FAIL r0_nostall got=%b%b exp=00", stall_pc, bubble_idex); n_fail++;
    end
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_cnt !== 3'd0) begin
      $display("FAIL r0_sels got=%b/%b cnt%0d exp=00/00 cnt0", fwd_a_sel, fwd_b_sel, stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_double_producer();
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
    tick();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
    tick();
    set_id(5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      $display("FAIL double_youngest got=%b/%b exp=01/01", fwd_a_sel, fwd_b_sel); n_fail++;
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);   // add r3
    tick();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw r5 <- [r3]
    tick();
    set_id(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0);   // reads r5
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({stall_pc, stall_ifid, bubble_idex, flush_ifid} !== 4'b1100) begin
        $display("FAIL ms_comb[%0d] got=%b exp=1100", i,
                 {stall_pc, stall_ifid, bubble_idex, flush_ifid}); n_fail++;
      end
      tick();
      n_checks++;
      if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00 || stall_cnt !== 3'd0) begin
        $display("FAIL ms_hold[%0d] got=%b/%b cnt%0d exp=01/00 cnt0", i, fwd_a_sel, fwd_b_sel,
                 stall_cnt); n_fail++;
      end
    end
    mem_stall = 1'b0;
    #1;
    n_checks++;
    if (bubble_idex !== 1'b1 || stall_pc !== 1'b1) begin
      $display("FAIL ms_resume_lu got=%b%b exp=11", bubble_idex, stall_pc); n_fail++;
    end
    tick();
    tick();
    n_checks++;
    if (fwd_b_sel !== 2'b10 || stall_cnt !== 3'd1) begin
      $display("FAIL ms_resume_fwd got=%b cnt%0d exp=10 cnt1", fwd_b_sel, stall_cnt); n_fail++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw r5
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);   // beq on r5, taken
    id_br_taken = 1'b1;
    #1;
    n_checks++;
    if (flush_ifid !== 1'b0 || stall_pc !== 1'b1) begin
      $display("FAIL br_lu got=flush%b stall%b exp=flush0 stall1", flush_ifid, stall_pc); n_fail++;
    end
    tick();
    n_checks++;
    if (flush_ifid !== 1'b1 || stall_pc !== 1'b0) begin
      $display("FAIL br_flush got=flush%b stall%b exp=flush1 stall0", flush_ifid, stall_pc); n_fail++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_id(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
      tick();
      set_id(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
      tick();
    end
    n_checks++;
    if (stall_cnt !== 3'd7) begin
      $display("FAIL cnt_saturate got=%0d exp=7", stall_cnt); n_fail++;
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    for (int i = 0; i < 3; i++) tick();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);   // add r3
    tick();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw r5 <- [r3]
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (stall_pc !== 1'b1 || fwd_a_sel !== 2'b01 || stall_cnt !== 3'd7) begin
      $display("FAIL rst_pre got=stall%b %b cnt%0d exp=stall1 01 cnt7", stall_pc, fwd_a_sel,
               stall_cnt); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall_pc, stall_ifid, bubble_idex} !== 3'b000 || fwd_a_sel !== 2'b00 ||
        fwd_b_sel !== 2'b00 || stall_cnt !== 3'd0) begin
      $display("FAIL rst_mid got=%b %b/%b cnt%0d exp=000 00/00 cnt0",
               {stall_pc, stall_ifid, bubble_idex}, fwd_a_sel, fwd_b_sel, stall_cnt); n_fail++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    mem_stall = 1'b0;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_r0();
    test_double_producer();
    test_mem_stall();
    test_branch();
    test_saturate();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
